// File: rtl/write_back.sv
// Final pipeline stage. Commits one execute bundle per handshake to the register file
// (with an optional second cycle for a high word) or to data memory, and reports retirement.
module write_back #(
  parameter int FLAGS_LSB       = 27,
  parameter int REG_INDEX_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_hold,
  input  logic [31:0]                pc,
  input  logic [REG_INDEX_WIDTH-1:0] target_register,
  input  logic                       is_writing_memory,
  input  logic [3:0]                 flags,
  input  logic [31:0]                target_value,
  input  logic                       has_upper_value,
  input  logic [31:0]                upper_value,
  input  logic [31:0]                adjustment_value,
  input  logic                       has_flushed,
  input  logic [31:0]                address_base,
  output logic                       rf_write_enable,
  output logic [REG_INDEX_WIDTH-1:0] rf_write_index,
  output logic [31:0]                rf_write_value,
  output logic                       flags_write_enable,
  output logic [3:0]                 flags_value,
  output logic                       mem_write,
  output logic [31:0]                mem_address,
  output logic [31:0]                mem_writedata,
  input  logic                       mem_waitrequest,
  output logic                       retire_valid,
  output logic [31:0]                retire_pc
);

  // The parent places flags_value at FLAGS_LSB; the field must fit inside a 32-bit word.
  if (FLAGS_LSB < 0 || FLAGS_LSB + 4 > 32) begin : g_bad_flags_lsb
    $error("write_back: FLAGS_LSB out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UPPER = 2'd1,
    S_MEM   = 2'd2
  } state_e;

  localparam logic [REG_INDEX_WIDTH-1:0] IDX_ZERO = REG_INDEX_WIDTH'(0);
  localparam logic [REG_INDEX_WIDTH-1:0] IDX_ONE  = REG_INDEX_WIDTH'(1);

  state_e                       state_q;
  logic [REG_INDEX_WIDTH-1:0]   upper_index_q;
  logic [31:0]                  upper_value_q;
  logic                         upper_en_q;
  logic [31:0]                  pend_pc_q;

  logic                         rf_we_q;
  logic [REG_INDEX_WIDTH-1:0]   rf_index_q;
  logic [31:0]                  rf_value_q;
  logic                         flags_we_q;
  logic [3:0]                   flags_q;
  logic                         mem_write_q;
  logic [31:0]                  mem_address_q;
  logic [31:0]                  mem_writedata_q;
  logic                         retire_q;
  logic [31:0]                  retire_pc_q;

  logic [REG_INDEX_WIDTH-1:0]   next_index_d;
  logic [31:0]                  store_addr_d;

  assign next_index_d = target_register + IDX_ONE;
  assign store_addr_d = address_base + adjustment_value;
  assign in_hold      = (state_q != S_IDLE);

  // Commit FSM; strobes default low each cycle, memory request persists across MEM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_IDLE;
      upper_index_q   <= IDX_ZERO;
      upper_value_q   <= 32'd0;
      upper_en_q      <= 1'b0;
      pend_pc_q       <= 32'd0;
      rf_we_q         <= 1'b0;
      rf_index_q      <= IDX_ZERO;
      rf_value_q      <= 32'd0;
      flags_we_q      <= 1'b0;
      flags_q         <= 4'd0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= 32'd0;
      mem_writedata_q <= 32'd0;
      retire_q        <= 1'b0;
      retire_pc_q     <= 32'd0;
    end else begin
      rf_we_q    <= 1'b0;
      flags_we_q <= 1'b0;
      retire_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_valid && !has_flushed) begin
            if (!is_writing_memory) begin
              rf_we_q    <= (target_register != IDX_ZERO);
              rf_index_q <= target_register;
              rf_value_q <= target_value;
              flags_we_q <= 1'b1;
              flags_q    <= flags;
              if (has_upper_value) begin
                state_q       <= S_UPPER;
                upper_index_q <= next_index_d;
                upper_value_q <= upper_value;
                upper_en_q    <= (target_register != IDX_ZERO) && (next_index_d != IDX_ZERO);
                pend_pc_q     <= pc;
              end else begin
                retire_q    <= 1'b1;
                retire_pc_q <= pc;
              end
            end else if (target_register == IDX_ZERO) begin
              // Failed compare-and-store: retires without touching memory.
              retire_q    <= 1'b1;
              retire_pc_q <= pc;
            end else begin
              mem_write_q     <= 1'b1;
              mem_address_q   <= store_addr_d;
              mem_writedata_q <= target_value;
              pend_pc_q       <= pc;
              state_q         <= S_MEM;
            end
          end
        end
        S_UPPER: begin
          rf_we_q     <= upper_en_q;
          rf_index_q  <= upper_index_q;
          rf_value_q  <= upper_value_q;
          retire_q    <= 1'b1;
          retire_pc_q <= pend_pc_q;
          state_q     <= S_IDLE;
        end
        S_MEM: begin
          if (!mem_waitrequest) begin
            mem_write_q <= 1'b0;
            retire_q    <= 1'b1;
            retire_pc_q <= pend_pc_q;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          mem_write_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rf_write_enable    = rf_we_q;
  assign rf_write_index     = rf_index_q;
  assign rf_write_value     = rf_value_q;
  assign flags_write_enable = flags_we_q;
  assign flags_value        = flags_q;
  assign mem_write          = mem_write_q;
  assign mem_address        = mem_address_q;
  assign mem_writedata      = mem_writedata_q;
  assign retire_valid       = retire_q;
  assign retire_pc          = retire_pc_q;

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_write_back;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_hold;
  logic [31:0] pc = 32'd0;
  logic [4:0]  target_register = 5'd0;
  logic        is_writing_memory = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic [31:0] target_value = 32'd0;
  logic        has_upper_value = 1'b0;
  logic [31:0] upper_value = 32'd0;
  logic [31:0] adjustment_value = 32'd0;
  logic        has_flushed = 1'b0;
  logic [31:0] address_base = 32'd0;
  logic        rf_write_enable;
  logic [4:0]  rf_write_index;
  logic [31:0] rf_write_value;
  logic        flags_write_enable;
  logic [3:0]  flags_value;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_waitrequest = 1'b0;
  logic        retire_valid;
  logic [31:0] retire_pc;

  write_back #(.FLAGS_LSB(27), .REG_INDEX_WIDTH(5)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_hold(in_hold),
    .pc(pc), .target_register(target_register), .is_writing_memory(is_writing_memory),
    .flags(flags), .target_value(target_value), .has_upper_value(has_upper_value),
    .upper_value(upper_value), .adjustment_value(adjustment_value), .has_flushed(has_flushed),
    .address_base(address_base), .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
    .rf_write_value(rf_write_value), .flags_write_enable(flags_write_enable), .flags_value(flags_value),
    .mem_write(mem_write), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest), .retire_valid(retire_valid), .retire_pc(retire_pc)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [4:0] idx; logic [31:0] val; int c; } rf_exp_t;
  typedef struct { logic [3:0] f; int c; } fl_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int c; } mem_exp_t;
  typedef struct { logic [31:0] pc; int c; } ret_exp_t;

  rf_exp_t  rf_q[$];
  fl_exp_t  fl_q[$];
  mem_exp_t mem_q[$];
  ret_exp_t ret_q[$];

  int checks = 0;
  int failures = 0;

  logic        mem_prev = 1'b0;
  logic [31:0] mem_addr_seen = 32'd0;
  logic [31:0] mem_data_seen = 32'd0;

  // Monitor: every strobe the DUT presents must match the head of its expectation queue.
  always @(negedge clock) begin
    rf_exp_t re; fl_exp_t fe; mem_exp_t me; ret_exp_t te;
    if (reset_n) begin
      if (rf_write_enable) begin
        checks++;
        if (rf_q.size() == 0) begin
          failures++; $display("FAIL rf_unexpected: got idx=%0d val=%h cyc=%0d, expected no write", rf_write_index, rf_write_value, cyc);
        end else begin
          re = rf_q.pop_front();
          if (rf_write_index !== re.idx || rf_write_value !== re.val || cyc != re.c) begin
            failures++; $display("FAIL rf_write: got idx=%0d val=%h cyc=%0d, expected idx=%0d val=%h cyc=%0d", rf_write_index, rf_write_value, cyc, re.idx, re.val, re.c);
          end
        end
      end
      if (flags_write_enable) begin
        checks++;
        if (fl_q.size() == 0) begin
          failures++; $display("FAIL flags_unexpected: got flags=%b cyc=%0d, expected no write", flags_value, cyc);
        end else begin
          fe = fl_q.pop_front();
          if (flags_value !== fe.f || cyc != fe.c) begin
            failures++; $display("FAIL flags_write: got flags=%b cyc=%0d, expected flags=%b cyc=%0d", flags_value, cyc, fe.f, fe.c);
          end
        end
      end
      if (retire_valid) begin
        checks++;
        if (ret_q.size() == 0) begin
          failures++; $display("FAIL retire_unexpected: got pc=%h cyc=%0d, expected no retire", retire_pc, cyc);
        end else begin
          te = ret_q.pop_front();
          if (retire_pc !== te.pc || cyc != te.c) begin
            failures++; $display("FAIL retire: got pc=%h cyc=%0d, expected pc=%h cyc=%0d", retire_pc, cyc, te.pc, te.c);
          end
        end
      end
      if (mem_write && !mem_prev) begin
        checks++;
        mem_addr_seen = mem_address;
        mem_data_seen = mem_writedata;
        if (mem_q.size() == 0) begin
          failures++; $display("FAIL mem_unexpected: got addr=%h data=%h cyc=%0d, expected no write", mem_address, mem_writedata, cyc);
        end else begin
          me = mem_q.pop_front();
          if (mem_address !== me.addr || mem_writedata !== me.data || cyc != me.c) begin
            failures++; $display("FAIL mem_write: got addr=%h data=%h cyc=%0d, expected addr=%h data=%h cyc=%0d", mem_address, mem_writedata, cyc, me.addr, me.data, me.c);
          end
        end
      end else if (mem_write && mem_prev) begin
        checks++;
        if (mem_address !== mem_addr_seen || mem_writedata !== mem_data_seen) begin
          failures++; $display("FAIL mem_stable: got addr=%h data=%h, expected addr=%h data=%h", mem_address, mem_writedata, mem_addr_seen, mem_data_seen);
        end
      end
      mem_prev = mem_write;
    end else begin
      mem_prev = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Ends at a negedge with the stage ready; returns the cycle at which a bundle driven now is accepted.
  task automatic wait_ready(output int acc);
    int n = 0;
    @(negedge clock);
    while (in_hold && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (in_hold) begin
      failures++;
      $display("FAIL ready_timeout: in_hold still %b after %0d cycles, expected 0", in_hold, n);
    end
    acc = cyc + 1;
  endtask

  task automatic drive(input logic [4:0] tr, input logic [31:0] tv, input logic [3:0] fl,
                       input logic up_en, input logic [31:0] up, input logic st,
                       input logic [31:0] base, input logic [31:0] adj, input logic fsh,
                       input logic [31:0] p);
    target_register = tr; target_value = tv; flags = fl; has_upper_value = up_en;
    upper_value = up; is_writing_memory = st; address_base = base; adjustment_value = adj;
    has_flushed = fsh; pc = p; in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    has_flushed = 1'b0;
  endtask

  initial begin
    int a;
    #12;
    check("reset_outputs", {59'd0, rf_write_enable, flags_write_enable, mem_write, retire_valid, in_hold}, 64'd0);
    check("reset_pc", {32'd0, retire_pc}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Add: single-cycle register commit.
    wait_ready(a);
    rf_q.push_back('{5'd3, 32'h0000_0005, a});
    fl_q.push_back('{4'b0000, a});
    ret_q.push_back('{32'h0000_0100, a});
    drive(5'd3, 32'h5, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h100);
    check("add_hold", {63'd0, in_hold}, 64'd0);

    // Multiply: low word, then high word into r5 with one bubble.
    wait_ready(a);
    rf_q.push_back('{5'd4, 32'hDEAD_BEEF, a});
    rf_q.push_back('{5'd5, 32'h1234_5678, a + 1});
    fl_q.push_back('{4'b1010, a});
    ret_q.push_back('{32'h0000_0104, a + 1});
    drive(5'd4, 32'hDEAD_BEEF, 4'b1010, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0, 32'h104);
    check("mul_hold_busy", {63'd0, in_hold}, 64'd1);
    @(posedge clock); #1;
    check("mul_hold_free", {63'd0, in_hold}, 64'd0);

    // Upper wrap: r31 + 1 wraps to r0, so the upper write is suppressed.
    wait_ready(a);
    rf_q.push_back('{5'd31, 32'h0000_0031, a});
    fl_q.push_back('{4'b0001, a});
    ret_q.push_back('{32'h0000_0108, a + 1});
    drive(5'd31, 32'h31, 4'b0001, 1'b1, 32'h99, 1'b0, 32'h0, 32'h0, 1'b0, 32'h108);
    check("wrap_hold", {63'd0, in_hold}, 64'd1);
    @(posedge clock); #1;
    check("wrap_upper", {58'd0, rf_write_enable, rf_write_index}, 64'd0);

    // Store with three wait cycles.
    mem_waitrequest = 1'b1;
    wait_ready(a);
    mem_q.push_back('{32'h0000_0FFC, 32'h0000_00AA, a});
    ret_q.push_back('{32'h0000_010C, a + 3});
    drive(5'd2, 32'hAA, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h1000, 32'hFFFF_FFFC, 1'b0, 32'h10C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("store_wait", {62'd0, mem_write, in_hold}, 64'd3);
    end
    mem_waitrequest = 1'b0;
    @(posedge clock); #1;
    check("store_release", {62'd0, mem_write, in_hold}, 64'd0);

    // Flushed bundles: nothing expected.
    wait_ready(a);
    drive(5'd6, 32'h66, 4'b0110, 1'b1, 32'h67, 1'b0, 32'h0, 32'h0, 1'b1, 32'h110);
    check("flush_reg_hold", {63'd0, in_hold}, 64'd0);
    wait_ready(a);
    drive(5'd7, 32'h77, 4'b0110, 1'b0, 32'h0, 1'b1, 32'h3000, 32'h4, 1'b1, 32'h114);
    check("flush_store", {62'd0, mem_write, in_hold}, 64'd0);

    // Dropped store (target 0): retire only.
    wait_ready(a);
    ret_q.push_back('{32'h0000_0118, a});
    drive(5'd0, 32'hBB, 4'b1111, 1'b0, 32'h0, 1'b1, 32'h5000, 32'h8, 1'b0, 32'h118);
    check("drop_store", {62'd0, mem_write, in_hold}, 64'd0);

    // Reset mid-MEM abandons the store.
    mem_waitrequest = 1'b1;
    wait_ready(a);
    mem_q.push_back('{32'h0000_2010, 32'h0000_0055, a});
    drive(5'd9, 32'h55, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h2000, 32'h10, 1'b0, 32'h11C);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_mem", {61'd0, mem_write, in_hold, retire_valid}, 64'd0);
    @(negedge clock);
    mem_waitrequest = 1'b0;
    reset_n = 1'b1;
    wait_ready(a);
    rf_q.push_back('{5'd10, 32'h0000_0077, a});
    fl_q.push_back('{4'b0101, a});
    ret_q.push_back('{32'h0000_0120, a});
    drive(5'd10, 32'h77, 4'b0101, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h120);
    check("after_reset_hold", {63'd0, in_hold}, 64'd0);

    repeat (5) @(negedge clock);
    check("rf_drained", 64'(rf_q.size()), 64'd0);
    check("flags_drained", 64'(fl_q.size()), 64'd0);
    check("mem_drained", 64'(mem_q.size()), 64'd0);
    check("retire_drained", 64'(ret_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
